// File: rtl/wb_pkg.sv
// Shared widths, state codes and helpers for the write buffer FIFO.
// Included by every write buffer file; optional macro WB_READ_FORWARD_EN.
package wb_pkg;

  localparam int WB_DEPTH    = 8;
  localparam int WB_ADDR_W   = 32;
  localparam int WB_LINE_W   = 256;
  localparam int WB_OFFSET_W = 5;

  localparam logic [1:0] STATE_EMPTY   = 2'd0;
  localparam logic [1:0] STATE_WORKING = 2'd1;
  localparam logic [1:0] STATE_FULL    = 2'd2;

  localparam logic HIT_SUCCESS = 1'b1;
  localparam logic HIT_FAIL    = 1'b0;

  function automatic logic [1:0] fifo_state(
    input int unsigned cnt,
    input int unsigned depth
  );
    if (cnt == 0)
      return STATE_EMPTY;
    else if (cnt == depth)
      return STATE_FULL;
    else
      return STATE_WORKING;
  endfunction

endpackage

// File: rtl/wb_tag_match.sv
// Parallel tag compare over all buffer entries.
// Yields a one-hot match vector and an any-hit flag.
module wb_tag_match
  import wb_pkg::*;
#(
  parameter int DEPTH = WB_DEPTH,
  parameter int TAG_W = WB_ADDR_W - WB_OFFSET_W
) (
  input  logic [TAG_W-1:0]             tag,
  input  logic [DEPTH-1:0]             valid,
  input  logic [DEPTH-1:0][TAG_W-1:0]  tags,
  output logic [DEPTH-1:0]             match,
  output logic                         hit
);

  always_comb begin
    match = '0;
    for (int i = 0; i < DEPTH; i++)
      match[i] = valid[i] && (tags[i] == tag);
  end

  assign hit = (|match) ? HIT_SUCCESS : HIT_FAIL;

endmodule

// File: rtl/write_buffer_fifo.sv
// Circular buffer of dirty cache lines feeding the AXI write adapter.
// Define WB_READ_FORWARD_EN to forward same-cycle write data to snoops.
module write_buffer_fifo
  import wb_pkg::*;
#(
  parameter int DEPTH    = WB_DEPTH,
  parameter int ADDR_W   = WB_ADDR_W,
  parameter int LINE_W   = WB_LINE_W,
  parameter int OFFSET_W = WB_OFFSET_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_wreq_i,
  input  logic [ADDR_W-1:0] cpu_awaddr_i,
  input  logic [LINE_W-1:0] cpu_wdata_i,
  output logic              write_hit_o,
  input  logic              cpu_rreq_i,
  input  logic [ADDR_W-1:0] cpu_araddr_i,
  output logic              read_hit_o,
  output logic [LINE_W-1:0] cpu_rdata_o,
  output logic [1:0]        state_o,
  output logic              mem_wen_o,
  output logic [LINE_W-1:0] mem_wdata_o,
  output logic [ADDR_W-1:0] mem_awaddr_o,
  input  logic              mem_bvalid_i
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int TAG_W = ADDR_W - OFFSET_W;
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

  logic [DEPTH-1:0]             valid_q;
  logic [DEPTH-1:0][TAG_W-1:0]  tag_q;
  logic [LINE_W-1:0]            data_q [DEPTH];
  logic [PTR_W-1:0]             head_q;
  logic [PTR_W-1:0]             tail_q;
  logic [PTR_W:0]               count_q;
  logic                         rewrite_q;

  logic [TAG_W-1:0]  wr_tag;
  logic [TAG_W-1:0]  rd_tag;
  logic [DEPTH-1:0]  wr_match;
  logic [DEPTH-1:0]  rd_match;
  logic              wr_hit;
  logic              rd_hit;
  logic [LINE_W-1:0] rd_line;
  logic              empty;
  logic              full;
  logic              head_rw;
  logic              pop;
  logic              push;
  logic              unused_offset;

  assign wr_tag = cpu_awaddr_i[ADDR_W-1:OFFSET_W];
  assign rd_tag = cpu_araddr_i[ADDR_W-1:OFFSET_W];
  assign unused_offset = ^{cpu_awaddr_i[OFFSET_W-1:0],
                           cpu_araddr_i[OFFSET_W-1:0]};

  wb_tag_match #(.DEPTH(DEPTH), .TAG_W(TAG_W)) u_wr_match (
    .tag   (wr_tag),
    .valid (valid_q),
    .tags  (tag_q),
    .match (wr_match),
    .hit   (wr_hit)
  );

  wb_tag_match #(.DEPTH(DEPTH), .TAG_W(TAG_W)) u_rd_match (
    .tag   (rd_tag),
    .valid (valid_q),
    .tags  (tag_q),
    .match (rd_match),
    .hit   (rd_hit)
  );

  assign empty   = (count_q == '0);
  assign full    = (count_q == FULL_CNT);
  assign head_rw = cpu_wreq_i && wr_hit && wr_match[head_q];

  // A head rewrite, pending or concurrent, turns bvalid into a re-send.
  assign pop  = mem_bvalid_i && !empty && !rewrite_q && !head_rw;
  assign push = cpu_wreq_i && !wr_hit && (!full || pop);

  always_comb begin
    rd_line = '0;
    for (int i = 0; i < DEPTH; i++)
      if (rd_match[i])
        rd_line = rd_line | data_q[i];
  end

  assign state_o      = fifo_state(32'(count_q), DEPTH);
  assign mem_wen_o    = !empty;
  assign mem_wdata_o  = empty ? '0 : data_q[head_q];
  assign mem_awaddr_o = empty ? '0
                      : {tag_q[head_q], {OFFSET_W{1'b0}}};

  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (cpu_wreq_i && wr_match[i])
        data_q[i] <= cpu_wdata_i;
      else if (push && tail_q == PTR_W'(i)) begin
        data_q[i] <= cpu_wdata_i;
        tag_q[i]  <= wr_tag;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q     <= '0;
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      rewrite_q   <= 1'b0;
      write_hit_o <= 1'b0;
      read_hit_o  <= 1'b0;
      cpu_rdata_o <= '0;
    end else begin
      // When full, pop and push share a slot; push must win the valid bit.
      if (pop) begin
        valid_q[head_q] <= 1'b0;
        head_q          <= head_q + 1'b1;
      end
      if (push) begin
        valid_q[tail_q] <= 1'b1;
        tail_q          <= tail_q + 1'b1;
      end
      if (push && !pop)
        count_q <= count_q + 1'b1;
      else if (pop && !push)
        count_q <= count_q - 1'b1;

      if (mem_bvalid_i && !empty)
        rewrite_q <= 1'b0;
      else if (head_rw)
        rewrite_q <= 1'b1;

      write_hit_o <= cpu_wreq_i && wr_hit;

      if (cpu_rreq_i) begin
`ifdef WB_READ_FORWARD_EN
        if (cpu_wreq_i && rd_tag == wr_tag) begin
          read_hit_o  <= HIT_SUCCESS;
          cpu_rdata_o <= cpu_wdata_i;
        end else begin
          read_hit_o  <= rd_hit;
          cpu_rdata_o <= rd_line;
        end
`else
        read_hit_o  <= rd_hit;
        cpu_rdata_o <= rd_line;
`endif
      end else begin
        read_hit_o <= HIT_FAIL;
      end
    end
  end

endmodule

// File: tb/tb_write_buffer_fifo.sv
// Self-checking bench for write_buffer_fifo: vector table plus
// hand-written drain and wrap sequences.
module tb_write_buffer_fifo;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         cpu_wreq_i = 1'b0;
  logic [31:0]  cpu_awaddr_i = '0;
  logic [255:0] cpu_wdata_i = '0;
  logic         write_hit_o;
  logic         cpu_rreq_i = 1'b0;
  logic [31:0]  cpu_araddr_i = '0;
  logic         read_hit_o;
  logic [255:0] cpu_rdata_o;
  logic [1:0]   state_o;
  logic         mem_wen_o;
  logic [255:0] mem_wdata_o;
  logic [31:0]  mem_awaddr_o;
  logic         mem_bvalid_i = 1'b0;

  int checks = 0;
  int failures = 0;

  write_buffer_fifo dut (
    .clk          (clk),
    .rst          (rst),
    .cpu_wreq_i   (cpu_wreq_i),
    .cpu_awaddr_i (cpu_awaddr_i),
    .cpu_wdata_i  (cpu_wdata_i),
    .write_hit_o  (write_hit_o),
    .cpu_rreq_i   (cpu_rreq_i),
    .cpu_araddr_i (cpu_araddr_i),
    .read_hit_o   (read_hit_o),
    .cpu_rdata_o  (cpu_rdata_o),
    .state_o      (state_o),
    .mem_wen_o    (mem_wen_o),
    .mem_wdata_o  (mem_wdata_o),
    .mem_awaddr_o (mem_awaddr_o),
    .mem_bvalid_i (mem_bvalid_i)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic         wreq;
    logic [31:0]  waddr;
    logic [255:0] wdata;
    logic         rreq;
    logic [31:0]  raddr;
    logic         bv;
    logic         e_whit;
    logic         e_rhit;
    logic [255:0] e_rdata;
    logic [1:0]   e_state;
    logic         e_wen;
    logic [31:0]  e_awaddr;
    logic [255:0] e_wdata;
  } vec_t;

  vec_t vecs[$];
  vec_t sb[$];

  function automatic logic [255:0] dl(input int i);
    return {8{32'(32'hD000_0000 + i)}};
  endfunction

  function automatic void add(
    input logic wreq, input logic [31:0] waddr,
    input logic [255:0] wdata, input logic rreq,
    input logic [31:0] raddr, input logic bv,
    input logic whit, input logic rhit,
    input logic [255:0] rdata, input logic [1:0] st,
    input logic wen, input logic [31:0] aw,
    input logic [255:0] wd
  );
    vec_t v;
    v.wreq = wreq; v.waddr = waddr; v.wdata = wdata;
    v.rreq = rreq; v.raddr = raddr; v.bv = bv;
    v.e_whit = whit; v.e_rhit = rhit; v.e_rdata = rdata;
    v.e_state = st; v.e_wen = wen;
    v.e_awaddr = aw; v.e_wdata = wd;
    vecs.push_back(v);
  endfunction

  task automatic chk(input string nm,
                     input logic [255:0] act,
                     input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h want=%0h", nm, act, exp);
    end
  endtask

  task automatic idle();
    cpu_wreq_i = 1'b0;
    cpu_rreq_i = 1'b0;
    mem_bvalid_i = 1'b0;
  endtask

  task automatic run(input int n, input vec_t v);
    vec_t e;
    cpu_wreq_i   = v.wreq;
    cpu_awaddr_i = v.waddr;
    cpu_wdata_i  = v.wdata;
    cpu_rreq_i   = v.rreq;
    cpu_araddr_i = v.raddr;
    mem_bvalid_i = v.bv;
    sb.push_back(v);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk($sformatf("v%0d_whit", n), 256'(write_hit_o), 256'(e.e_whit));
    chk($sformatf("v%0d_rhit", n), 256'(read_hit_o), 256'(e.e_rhit));
    chk($sformatf("v%0d_rdata", n), cpu_rdata_o, e.e_rdata);
    chk($sformatf("v%0d_state", n), 256'(state_o), 256'(e.e_state));
    chk($sformatf("v%0d_wen", n), 256'(mem_wen_o), 256'(e.e_wen));
    chk($sformatf("v%0d_awaddr", n), 256'(mem_awaddr_o), 256'(e.e_awaddr));
    chk($sformatf("v%0d_wdata", n), mem_wdata_o, e.e_wdata);
  endtask

  localparam logic [255:0] Z = '0;
  localparam logic [255:0] W1 = 256'h1111;
  localparam logic [255:0] W2 = 256'h2222;
  localparam logic [255:0] W3 = 256'h3333;

  initial begin
    logic [31:0] lines [8];
    logic [255:0] fwd_data;
    int cyc;
    lines = '{32'h24687571, 32'h24697571, 32'h25687571, 32'h24617571,
              32'h24387571, 32'h24307571, 32'h14387571, 32'h74387571};
`ifdef WB_READ_FORWARD_EN
    fwd_data = W3;
`else
    fwd_data = dl(2);
`endif

    add(1, lines[0], dl(0), 0, 0, 0, 0, 0, Z, 1, 1, 32'h24687560, dl(0));
    add(0, 0, Z, 0, 0, 1, 0, 0, Z, 0, 0, 0, Z);
    for (int i = 0; i < 8; i++)
      add(1, lines[i], dl(i), 0, 0, 0, 0, 0, Z,
          (i == 7) ? 2'd2 : 2'd1, 1, 32'h24687560, dl(0));
    add(0, 0, Z, 1, 32'h99617560, 0, 0, 0, Z, 2, 1, 32'h24687560, dl(0));
    add(0, 0, Z, 1, 32'h24617560, 0, 0, 1, dl(3), 2, 1, 32'h24687560, dl(0));
    add(0, 0, Z, 0, 0, 1, 0, 0, dl(3), 1, 1, 32'h24697560, dl(1));
    add(0, 0, Z, 1, 32'h24687560, 0, 0, 0, Z, 1, 1, 32'h24697560, dl(1));
    add(1, 32'h24617573, Z, 0, 0, 0, 1, 0, Z, 1, 1, 32'h24697560, dl(1));
    add(0, 0, Z, 1, 32'h24617560, 0, 0, 1, Z, 1, 1, 32'h24697560, dl(1));
    add(1, 32'h2469756b, W1, 0, 0, 0, 1, 0, Z, 1, 1, 32'h24697560, W1);
    add(0, 0, Z, 0, 0, 1, 0, 0, Z, 1, 1, 32'h24697560, W1);
    add(0, 0, Z, 1, 32'h2469756b, 0, 0, 1, W1, 1, 1, 32'h24697560, W1);
    add(1, 32'h24697571, W2, 0, 0, 1, 1, 0, W1, 1, 1, 32'h24697560, W2);
    add(0, 0, Z, 0, 0, 1, 0, 0, W1, 1, 1, 32'h25687560, dl(2));
    add(1, lines[2], W3, 1, lines[2], 0, 1, 1, fwd_data,
        1, 1, 32'h25687560, W3);
    add(0, 0, Z, 0, 0, 1, 0, 0, fwd_data, 1, 1, 32'h25687560, W3);
    add(1, 32'h00000020, dl(20), 0, 0, 0, 0, 0, fwd_data,
        1, 1, 32'h25687560, W3);
    add(1, 32'h00000040, dl(21), 0, 0, 0, 0, 0, fwd_data,
        2, 1, 32'h25687560, W3);
    add(1, 32'h00000060, dl(22), 0, 0, 1, 0, 0, fwd_data,
        2, 1, 32'h24617560, Z);
    add(0, 0, Z, 1, 32'h0000007f, 0, 0, 1, dl(22), 2, 1, 32'h24617560, Z);

    #3;
    chk("rst_state", 256'(state_o), 256'(2'd0));
    chk("rst_wen", 256'(mem_wen_o), 256'(1'b0));
    chk("rst_awaddr", 256'(mem_awaddr_o), 256'(32'h0));
    chk("rst_wdata", mem_wdata_o, Z);
    chk("rst_hits", 256'({write_hit_o, read_hit_o}), 256'(2'b00));
    chk("rst_rdata", cpu_rdata_o, Z);
    #19;
    rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++)
      run(i, vecs[i]);
    idle();

    cyc = 0;
    mem_bvalid_i = 1'b1;
    while (mem_wen_o && cyc < 20) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    mem_bvalid_i = 1'b0;
    chk("drain_pops", 256'(cyc), 256'(8));
    chk("drain_state", 256'(state_o), 256'(2'd0));

    mem_bvalid_i = 1'b1;
    @(posedge clk);
    #1;
    mem_bvalid_i = 1'b0;
    chk("bv_empty_state", 256'(state_o), 256'(2'd0));
    chk("bv_empty_wen", 256'(mem_wen_o), 256'(1'b0));

    cpu_wreq_i = 1'b1;
    cpu_awaddr_i = 32'h74387571;
    cpu_wdata_i = dl(9);
    cpu_rreq_i = 1'b1;
    cpu_araddr_i = 32'h00000040;
    @(posedge clk);
    #1;
    idle();
    chk("wrap_state", 256'(state_o), 256'(2'd1));
    chk("wrap_awaddr", 256'(mem_awaddr_o), 256'(32'h74387560));
    chk("wrap_wdata", mem_wdata_o, dl(9));
    chk("wrap_whit", 256'(write_hit_o), 256'(1'b0));
    chk("popped_rhit", 256'(read_hit_o), 256'(1'b0));

    mem_bvalid_i = 1'b1;
    @(posedge clk);
    #1;
    idle();
    chk("final_state", 256'(state_o), 256'(2'd0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
